cpa_multiword_sequencer: RTL and testbench



---
 rtl/cpa_multiword_sequencer.sv | 169 ++++++++++++++++
 tb/tb_cpa_multiword_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpa_multiword_sequencer.sv
// Multi-cycle wide adder/subtractor. One BITS-wide Ladner-Fisher prefix adder is
// reused across WORDS chunks, LSB chunk first, with a registered carry between chunks.
// Optional macro CPA_SEQ_OVF_EN adds out_ovf (signed overflow of the full-width result).
module cpa_multiword_sequencer #(
   parameter int BITS  = 16,
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BITS*WORDS-1:0] in_a,
   input  logic [BITS*WORDS-1:0] in_b,
   input  logic                  in_ci,
   input  logic                  in_sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BITS*WORDS-1:0] out_sum,
   output logic                  out_co,
   output logic                  busy
`ifdef CPA_SEQ_OVF_EN
   ,
   output logic                  out_ovf
`endif
);

   localparam int W  = BITS * WORDS;
   localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;      // already inverted for subtraction
   logic [W-1:0]    sum_q, sum_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            carry_q, carry_d;
   logic            co_q, co_d;
   logic            out_valid_q, out_valid_d;
   logic            in_ready_q, in_ready_d;
   logic            busy_q, busy_d;
`ifdef CPA_SEQ_OVF_EN
   logic            ovf_q, ovf_d;
`endif

   logic [BITS-1:0] add_a, add_b, add_s;
   logic            add_co;
   logic [BITS-1:0] gen, prop, grp_g, grp_p;
   logic [BITS:0]   carry_vec;
   logic            last_chunk;

   assign add_a      = a_q[cnt_q*BITS +: BITS];
   assign add_b      = b_q[cnt_q*BITS +: BITS];
   assign last_chunk = (cnt_q == CW'(WORDS - 1));

   // Ladner-Fisher prefix tree over the chunk; carry-in folded in after the tree
   always_comb begin
      gen   = add_a & add_b;
      prop  = add_a ^ add_b;
      grp_g = gen;
      grp_p = prop;
      for (int l = 0; (1 << l) < BITS; l++) begin
         for (int i = 0; i < BITS; i++) begin
            if (((i >> l) & 1) == 1) begin
               grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[((i >> l) << l) - 1]);
               grp_p[i] = grp_p[i] & grp_p[((i >> l) << l) - 1];
            end
         end
      end
      carry_vec[0] = carry_q;
      for (int i = 0; i < BITS; i++) begin
         carry_vec[i+1] = grp_g[i] | (grp_p[i] & carry_q);
      end
      add_s  = prop ^ carry_vec[BITS-1:0];
      add_co = carry_vec[BITS];
   end

   // Next-state, datapath capture and chunk write-back
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      sum_d       = sum_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      co_d        = co_q;
      out_valid_d = out_valid_q;
`ifdef CPA_SEQ_OVF_EN
      ovf_d       = ovf_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (in_valid && in_ready_q) begin
               a_d     = in_a;
               b_d     = in_sub ? ~in_b : in_b;
               carry_d = in_sub ^ in_ci;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            sum_d[cnt_q*BITS +: BITS] = add_s;
            carry_d                   = add_co;
            if (last_chunk) begin
               state_d     = StDone;
               out_valid_d = 1'b1;
               co_d        = add_co;
`ifdef CPA_SEQ_OVF_EN
               ovf_d = (a_q[W-1] == b_q[W-1]) & (add_s[BITS-1] != a_q[W-1]);
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d     = StIdle;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
      in_ready_d = (state_d == StIdle);
      busy_d     = (state_d != StIdle);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         co_q        <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
`ifdef CPA_SEQ_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         co_q        <= co_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
`ifdef CPA_SEQ_OVF_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = sum_q;
   assign out_co    = co_q;
   assign busy      = busy_q;
`ifdef CPA_SEQ_OVF_EN
   assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_cpa_multiword_sequencer.sv
// Self-checking bench for cpa_multiword_sequencer at BITS=4, WORDS=4 (W=16).
// Define CPA_SEQ_OVF_EN to also exercise out_ovf.
module tb_cpa_multiword_sequencer;

   localparam int BITS  = 4;
   localparam int WORDS = 4;
   localparam int W     = BITS * WORDS;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_ci;
   logic         in_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_co;
   logic         busy;
`ifdef CPA_SEQ_OVF_EN
   logic         out_ovf;
`endif

   int tests = 0;
   int fails = 0;

   logic [W-1:0] exp_sum;
   logic         exp_co;
   logic         exp_ovf;

   cpa_multiword_sequencer #(
      .BITS  (BITS),
      .WORDS (WORDS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_ci     (in_ci),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_co    (out_co),
      .busy      (busy)
`ifdef CPA_SEQ_OVF_EN
      ,
      .out_ovf   (out_ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain W+1-bit arithmetic
   task automatic set_model(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input logic sub);
      logic [W:0]   r;
      logic [W-1:0] bp;
      bp = sub ? ~b : b;
      if (sub) r = {1'b0, a} + {1'b0, bp} + {16'd0, ~ci};
      else     r = {1'b0, a} + {1'b0, b} + {16'd0, ci};
      exp_sum = r[W-1:0];
      exp_co  = r[W];
      exp_ovf = (a[W-1] == bp[W-1]) && (r[W-1] != a[W-1]);
   endtask

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sub);
      in_a     = a;
      in_b     = b;
      in_ci    = ci;
      in_sub   = sub;
      in_valid = 1'b1;
      set_model(a, b, ci, sub);
   endtask

   task automatic scramble_inputs();
      in_a   = 16'($urandom);
      in_b   = 16'($urandom);
      in_ci  = 1'($urandom);
      in_sub = 1'($urandom);
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sub);
      int n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      check("in_ready_wait", 32'(in_ready), 32'd1);
      drive(a, b, ci, sub);
      step();
      in_valid = 1'b0;
      scramble_inputs();
      check("busy_after_accept", 32'(busy), 32'd1);
      check("in_ready_after_accept", 32'(in_ready), 32'd0);
   endtask

   task automatic wait_result(input string tag);
      for (int i = 1; i < WORDS; i++) begin
         step();
         check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
      end
      step();
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
      check({tag, "_co"}, 32'(out_co), 32'(exp_co));
`ifdef CPA_SEQ_OVF_EN
      check({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
`endif
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("release_valid", 32'(out_valid), 32'd0);
      check("release_in_ready", 32'(in_ready), 32'd1);
      check("release_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [W-1:0] held_sum;
      logic         held_co;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      scramble_inputs();
      step();
      step();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_sum", 32'(out_sum), 32'd0);
      check("rst_out_co", 32'(out_co), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      step();
      check("rst_release_in_ready", 32'(in_ready), 32'd1);

      // Directed arithmetic cases
      issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
      wait_result("add_00ff");
      release_result();
      issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait_result("add_ripple");
      release_result();
      issue(16'h1234, 16'h0235, 1'b0, 1'b1);
      wait_result("sub_1234");
      release_result();
      issue(16'h0000, 16'h0001, 1'b0, 1'b1);
      wait_result("sub_borrow");
      release_result();
      check("sub_borrow_lit_sum", 32'(exp_sum), 32'h0000FFFF);

      // DONE stall with a competing request
      issue(16'h1111, 16'h2222, 1'b1, 1'b0);
      wait_result("stall");
      held_sum = exp_sum;
      held_co  = exp_co;
      drive(16'h0F0F, 16'h0101, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_sum", 32'(out_sum), 32'(held_sum));
         check("stall_co", 32'(out_co), 32'(held_co));
         check("stall_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("stall_release_valid", 32'(out_valid), 32'd0);
      check("stall_release_in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      scramble_inputs();
      check("stall_new_accept", 32'(busy), 32'd1);
      wait_result("stall_new");
      release_result();

      // Reset in the middle of RUN
      issue(16'hABCD, 16'h1357, 1'b0, 1'b0);
      step();
      step();
      rst_n = 1'b0;
      step();
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_sum", 32'(out_sum), 32'd0);
      check("midrst_out_co", 32'(out_co), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
`ifdef CPA_SEQ_OVF_EN
      check("midrst_out_ovf", 32'(out_ovf), 32'd0);
`endif
      rst_n = 1'b1;
      step();
      check("midrst_release_in_ready", 32'(in_ready), 32'd1);
      issue(16'h0001, 16'h0001, 1'b0, 1'b0);
      wait_result("after_rst");
      release_result();

`ifdef CPA_SEQ_OVF_EN
      issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      wait_result("ovf_add");
      release_result();
      issue(16'h8000, 16'h0001, 1'b0, 1'b1);
      wait_result("ovf_sub");
      release_result();
`endif

      // Randomized operations with random consumer stalls
      for (int t = 0; t < 30; t++) begin
         issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
         wait_result("rand");
         for (int s = 0; s < int'($urandom_range(0, 3)); s++) step();
         release_result();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
